riscv_wb_stage: RTL and testbench

Writeback stage of the RISC-V pipeline: MEM/WB pipeline register plus load-data extraction and result selection, driving the write port (`AddrD_i`, `DataD_i`, `RegWEn_i`) of `riscv_regfile`. It captures one instruction per cycle from the memory stage and supports stall and flush. It also suppresses writes to x0, so the register file only ever sees legal, idempotent writes.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/riscv_load_align.sv | 31 +++
 rtl/riscv_wb_stage.sv | 136 +++++++++++++
 tb/tb_riscv_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V writeback datapath.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback result source
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/riscv_load_align.sv
// Load data extraction: picks byte/halfword/word from an aligned memory word and extends it.
// Latency: purely combinational.
// Backpressure: none.
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/halfword, then sign- or zero-extend by load type.
  // Halfword selection uses only offset[1]; misaligned offset[0] is ignored.
  // Unlisted funct3 codes fall back to the full word.
  always_comb begin
    byte_sel = word_i[8*offset_i +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// Writeback stage: MEM/WB register, load extraction and result select feeding the regfile write port.
// Latency: 1 cycle from inputs to outputs; the regfile commits on the following edge.
// Backpressure: Stall_i holds the register (held write repeats, idempotent); Flush_i kills the capture and wins over stall.
// Optional: RISCV_WB_INSTRET_EN adds a 64-bit retired-instruction counter on Instret_o.
module riscv_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Valid_i,
  input  logic [4:0]      Rd_i,
  input  logic            RegWEn_i,
  input  logic [1:0]      WbSel_i,
  input  logic [2:0]      Funct3_i,
  input  logic [XLEN-1:0] AluRes_i,
  input  logic [XLEN-1:0] MemRData_i,
  input  logic [XLEN-1:0] Pc_i,
  input  logic            Stall_i,
  input  logic            Flush_i,
  output logic [4:0]      AddrD_o,
  output logic [XLEN-1:0] DataD_o,
  output logic            RegWEn_o,
  output logic            Valid_o
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]     Instret_o
`endif
);

  logic            valid_q,    valid_d;
  logic [4:0]      rd_q,       rd_d;
  logic            regwen_q,   regwen_d;
  wb_sel_e         wbsel_q,    wbsel_d;
  logic [2:0]      funct3_q,   funct3_d;
  logic [XLEN-1:0] alures_q,   alures_d;
  logic [XLEN-1:0] memrdata_q, memrdata_d;
  logic [XLEN-1:0] pc_q,       pc_d;

  logic [XLEN-1:0] load_res;

  // Next-state: flush clears valid only (payload is don't-care, so it just holds),
  // stall holds everything, otherwise capture the memory stage.
  always_comb begin
    valid_d    = valid_q;
    rd_d       = rd_q;
    regwen_d   = regwen_q;
    wbsel_d    = wbsel_q;
    funct3_d   = funct3_q;
    alures_d   = alures_q;
    memrdata_d = memrdata_q;
    pc_d       = pc_q;
    if (Flush_i) begin
      valid_d = 1'b0;
    end else if (!Stall_i) begin
      valid_d    = Valid_i;
      rd_d       = Rd_i;
      regwen_d   = RegWEn_i;
      wbsel_d    = wb_sel_e'(WbSel_i);
      funct3_d   = Funct3_i;
      alures_d   = AluRes_i;
      memrdata_d = MemRData_i;
      pc_d       = Pc_i;
    end
  end

  // MEM/WB pipeline register; reset drops any in-flight instruction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      regwen_q   <= 1'b0;
      wbsel_q    <= WB_ALU;
      funct3_q   <= '0;
      alures_q   <= '0;
      memrdata_q <= '0;
      pc_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      regwen_q   <= regwen_d;
      wbsel_q    <= wbsel_d;
      funct3_q   <= funct3_d;
      alures_q   <= alures_d;
      memrdata_q <= memrdata_d;
      pc_q       <= pc_d;
    end
  end

  riscv_load_align u_load_align (
    .funct3_i (funct3_q),
    .offset_i (alures_q[1:0]),
    .word_i   (memrdata_q),
    .result_o (load_res)
  );

  // Result select; the reserved source yields zero so it can never leak stale data.
  always_comb begin
    case (wbsel_q)
      WB_ALU:  DataD_o = alures_q;
      WB_MEM:  DataD_o = load_res;
      WB_PC4:  DataD_o = pc_q + XLEN'(4);
      default: DataD_o = '0;
    endcase
  end

  assign Valid_o  = valid_q;
  assign AddrD_o  = rd_q;
  // x0 writes and the reserved source are suppressed so the regfile only sees legal writes.
  assign RegWEn_o = valid_q & regwen_q & (rd_q != 5'd0) & (wbsel_q != WB_RSVD);

`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // An instruction retires on the edge it leaves WB (not held), so a stall counts it once.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && (!Stall_i || Flush_i)) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign Instret_o = instret_q;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Bench for riscv_wb_stage: vector table, hand-written stall/flush/reset sequences, random vs reference model.
module tb_riscv_wb_stage;

  logic        clk_i;
  logic        rst_i;
  logic        Valid_i;
  logic [4:0]  Rd_i;
  logic        RegWEn_i;
  logic [1:0]  WbSel_i;
  logic [2:0]  Funct3_i;
  logic [31:0] AluRes_i;
  logic [31:0] MemRData_i;
  logic [31:0] Pc_i;
  logic        Stall_i;
  logic        Flush_i;
  logic [4:0]  AddrD_o;
  logic [31:0] DataD_o;
  logic        RegWEn_o;
  logic        Valid_o;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] Instret_o;
`endif

  riscv_wb_stage #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .Valid_i    (Valid_i),
    .Rd_i       (Rd_i),
    .RegWEn_i   (RegWEn_i),
    .WbSel_i    (WbSel_i),
    .Funct3_i   (Funct3_i),
    .AluRes_i   (AluRes_i),
    .MemRData_i (MemRData_i),
    .Pc_i       (Pc_i),
    .Stall_i    (Stall_i),
    .Flush_i    (Flush_i),
    .AddrD_o    (AddrD_o),
    .DataD_o    (DataD_o),
    .RegWEn_o   (RegWEn_o),
    .Valid_o    (Valid_o)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .Instret_o  (Instret_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register file model fed by the DUT write port
  logic [31:0] tb_rf [32];
  logic        rf_init;
  always @(posedge clk_i) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (RegWEn_o) begin
      tb_rf[AddrD_o] <= DataD_o;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic stall, input logic flush);
    Valid_i = vld; Rd_i = rd; RegWEn_i = we; WbSel_i = sel; Funct3_i = f3;
    AluRes_i = alu; MemRData_i = mem; Pc_i = pc; Stall_i = stall; Flush_i = flush;
  endtask

  typedef struct {
    logic        vld;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        exp_vld;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  localparam logic [31:0] MEMW = 32'h80F0_7F81;

  // Reference model: the instruction currently held in WB, at the architectural level
  typedef struct {
    logic        vld;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
  } instr_t;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    int unsigned off = addr % 4;
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_data(input instr_t m);
    case (m.sel)
      2'd0: return m.alu;
      2'd1: return ref_load(m.f3, m.alu, m.mem);
      2'd2: return m.pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  vec_t   vecs [16];
  instr_t m;
  instr_t nxt;
  logic   r_stall, r_flush;
  logic [63:0] ref_cnt;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] c0;
`endif

  initial begin
    // ---------------- reset ----------------
    rst_i = 1'b0;
    rf_init = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rf_init = 1'b0;
    check("rst_valid", 64'(Valid_o), 64'd0);
    check("rst_we", 64'(RegWEn_o), 64'd0);
    check("rst_addr", 64'(AddrD_o), 64'd0);
    check("rst_data", 64'(DataD_o), 64'd0);
`ifdef RISCV_WB_INSTRET_EN
    check("rst_instret", Instret_o, 64'd0);
`endif
    rst_i = 1'b1;

    // ---------------- vector table ----------------
    //          vld rd    we  sel f3    alu            pc              exp_vld addr data           we
    vecs[0]  = '{1, 5'd2, 1, 0, 3'd0, 32'h0000_0016, 32'h0,          1, 5'd2, 32'h0000_0016, 1};
    vecs[1]  = '{1, 5'd3, 1, 1, 3'd0, 32'h0000_1000, 32'h0,          1, 5'd3, 32'hFFFF_FF81, 1};
    vecs[2]  = '{1, 5'd3, 1, 1, 3'd4, 32'h0000_1003, 32'h0,          1, 5'd3, 32'h0000_0080, 1};
    vecs[3]  = '{1, 5'd3, 1, 1, 3'd1, 32'h0000_1002, 32'h0,          1, 5'd3, 32'hFFFF_80F0, 1};
    vecs[4]  = '{1, 5'd3, 1, 1, 3'd5, 32'h0000_1003, 32'h0,          1, 5'd3, 32'h0000_80F0, 1};
    vecs[5]  = '{1, 5'd3, 1, 1, 3'd2, 32'h0000_1001, 32'h0,          1, 5'd3, 32'h80F0_7F81, 1};
    vecs[6]  = '{1, 5'd3, 1, 1, 3'd3, 32'h0000_1002, 32'h0,          1, 5'd3, 32'h80F0_7F81, 1};
    vecs[7]  = '{1, 5'd3, 1, 1, 3'd0, 32'h0000_1001, 32'h0,          1, 5'd3, 32'h0000_007F, 1};
    vecs[8]  = '{1, 5'd3, 1, 1, 3'd1, 32'h0000_1000, 32'h0,          1, 5'd3, 32'h0000_7F81, 1};
    vecs[9]  = '{1, 5'd3, 1, 1, 3'd4, 32'h0000_1002, 32'h0,          1, 5'd3, 32'h0000_00F0, 1};
    vecs[10] = '{1, 5'd0, 1, 0, 3'd0, 32'h0000_0055, 32'h0,          1, 5'd0, 32'h0000_0055, 0};
    vecs[11] = '{1, 5'd4, 1, 3, 3'd0, 32'h0000_0044, 32'h0,          1, 5'd4, 32'h0000_0000, 0};
    vecs[12] = '{1, 5'd1, 1, 2, 3'd0, 32'h0000_0000, 32'hFFFF_FFFC,  1, 5'd1, 32'h0000_0000, 1};
    vecs[13] = '{1, 5'd1, 1, 2, 3'd0, 32'h0000_0000, 32'h0000_0100,  1, 5'd1, 32'h0000_0104, 1};
    vecs[14] = '{0, 5'd5, 1, 0, 3'd0, 32'h0000_0077, 32'h0,          0, 5'd5, 32'h0000_0077, 0};
    vecs[15] = '{1, 5'd6, 0, 0, 3'd0, 32'h0000_0066, 32'h0,          1, 5'd6, 32'h0000_0066, 0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vld, vecs[i].rd, vecs[i].we, vecs[i].sel, vecs[i].f3, vecs[i].alu, MEMW, vecs[i].pc, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(Valid_o), 64'(vecs[i].exp_vld));
      check($sformatf("vec%0d_addr", i), 64'(AddrD_o), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i), 64'(DataD_o), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_we", i), 64'(RegWEn_o), 64'(vecs[i].exp_we));
    end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("rf_r2", 64'(tb_rf[2]), 64'h16);
    check("rf_r0_untouched", 64'(tb_rf[0]), 64'hA5A5_0000);
    check("rf_r4_untouched", 64'(tb_rf[4]), 64'hA5A5_0004);

    // ---------------- stall 3 cycles ----------------
    drive(1'b1, 5'd10, 1'b1, 2'd0, 3'd0, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
`ifdef RISCV_WB_INSTRET_EN
    c0 = Instret_o;
`endif
    drive(1'b1, 5'd11, 1'b1, 2'd0, 3'd0, 32'h44, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_addr", k), 64'(AddrD_o), 64'd10);
      check($sformatf("stall%0d_data", k), 64'(DataD_o), 64'h33);
      check($sformatf("stall%0d_we", k), 64'(RegWEn_o), 64'd1);
`ifdef RISCV_WB_INSTRET_EN
      check($sformatf("stall%0d_instret", k), Instret_o, c0);
`endif
    end
    drive(1'b0, 5'd11, 1'b1, 2'd0, 3'd0, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("stall_release_valid", 64'(Valid_o), 64'd0);
`ifdef RISCV_WB_INSTRET_EN
    check("stall_instret_plus1", Instret_o, c0 + 64'd1);
`endif
    tick();
    check("rf_r10", 64'(tb_rf[10]), 64'h33);
`ifdef RISCV_WB_INSTRET_EN
    check("stall_instret_idle", Instret_o, c0 + 64'd1);
`endif

    // ---------------- flush ----------------
    drive(1'b1, 5'd7, 1'b1, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check("flush_valid", 64'(Valid_o), 64'd0);
    check("flush_we", 64'(RegWEn_o), 64'd0);
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("flush_r7_unchanged", 64'(tb_rf[7]), 64'hA5A5_0007);

    // ---------------- flush + stall ----------------
    drive(1'b1, 5'd12, 1'b1, 2'd0, 3'd0, 32'hC0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("fs_pre_valid", 64'(Valid_o), 64'd1);
`ifdef RISCV_WB_INSTRET_EN
    c0 = Instret_o;
`endif
    drive(1'b1, 5'd13, 1'b1, 2'd0, 3'd0, 32'hD0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    check("fs_valid", 64'(Valid_o), 64'd0);
    check("fs_we", 64'(RegWEn_o), 64'd0);
`ifdef RISCV_WB_INSTRET_EN
    check("fs_instret", Instret_o, c0 + 64'd1);
`endif

    // ---------------- reset mid-operation ----------------
    drive(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("midrst_pre_we", 64'(RegWEn_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_async_we", 64'(RegWEn_o), 64'd0);
    check("midrst_async_valid", 64'(Valid_o), 64'd0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("midrst_r9_unchanged", 64'(tb_rf[9]), 64'hA5A5_0009);

    // ---------------- random vs reference model ----------------
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    m = '{1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0};
    ref_cnt = 64'd0;
    for (int n = 0; n < 400; n++) begin
      nxt.vld = 1'($urandom_range(0, 3) != 0);
      nxt.rd  = 5'($urandom_range(0, 31));
      nxt.we  = 1'($urandom_range(0, 4) != 0);
      nxt.sel = 2'($urandom_range(0, 3));
      nxt.f3  = 3'($urandom_range(0, 7));
      nxt.alu = $urandom;
      nxt.mem = $urandom;
      nxt.pc  = (n % 17 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      r_stall = ($urandom_range(0, 4) == 0);
      r_flush = ($urandom_range(0, 9) == 0);
      drive(nxt.vld, nxt.rd, nxt.we, nxt.sel, nxt.f3, nxt.alu, nxt.mem, nxt.pc, r_stall, r_flush);
      tick();
      if (m.vld && (!r_stall || r_flush)) ref_cnt = ref_cnt + 64'd1;
      if (r_flush) m.vld = 1'b0;
      else if (!r_stall) m = nxt;
      check($sformatf("rnd%0d_valid", n), 64'(Valid_o), 64'(m.vld));
      check($sformatf("rnd%0d_we", n), 64'(RegWEn_o),
            64'(m.vld && m.we && (m.rd != 5'd0) && (m.sel != 2'd3)));
      if (m.vld) begin
        check($sformatf("rnd%0d_addr", n), 64'(AddrD_o), 64'(m.rd));
        check($sformatf("rnd%0d_data", n), 64'(DataD_o), 64'(ref_data(m)));
      end
`ifdef RISCV_WB_INSTRET_EN
      check($sformatf("rnd%0d_instret", n), Instret_o, ref_cnt);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
